// File: rtl/key_expand.sv
// AES-128 key schedule: emits round keys 0..10, two cycles per round,
// using four registered S-box lookups for SubWord.
`timescale 1ns/1ps

// Registered AES S-box: GF(2^8) inverse followed by the affine transform,
// result available one clock after the input is presented. No reset.
module sbox (
   input  logic       clk,
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] x;
      r = 8'h01;
      x = a;
      for (int i = 0; i < 7; i++) begin
         x = gf_mul(x, x);
         r = gf_mul(r, x);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox_f(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // Lookup register; contents are don't-care until first use after start
   always_ff @(posedge clk) begin
      s_o <= sbox_f(a_i);
   end

endmodule

module key_expand (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   output logic [3:0]   rk_round,
   output logic [127:0] round_key,
   output logic         done
);

   typedef enum logic [1:0] {IDLE, SUB, MIX} state_t;

   state_t        state_q;
   logic [127:0]  key_q;
   logic [3:0]    rcnt_q;
   logic [7:0]    rcon_q;

   logic [31:0]   rot_w;
   logic [31:0]   sub_w;
   logic [31:0]   t_w;
   logic [31:0]   w0_d, w1_d, w2_d, w3_d;
   logic [127:0]  key_d;
   logic [7:0]    rcon_d;

   // RotWord(w3): w3 is the least significant word of the key register
   assign rot_w = {key_q[23:0], key_q[31:24]};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sbox
         sbox u_sbox (
            .clk (clk),
            .a_i (rot_w[8*gi +: 8]),
            .s_o (sub_w[8*gi +: 8])
         );
      end
   endgenerate

   // Next round key and next rcon, consumed only in MIX
   always_comb begin
      t_w    = sub_w ^ {rcon_q, 24'h000000};
      w0_d   = key_q[127:96] ^ t_w;
      w1_d   = key_q[95:64]  ^ w0_d;
      w2_d   = key_q[63:32]  ^ w1_d;
      w3_d   = key_q[31:0]   ^ w2_d;
      key_d  = {w0_d, w1_d, w2_d, w3_d};
      rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
   end

   // Control FSM with registered outputs; SUB waits for the S-box registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         key_q     <= '0;
         rcnt_q    <= 4'd0;
         rcon_q    <= 8'h01;
         busy      <= 1'b0;
         rk_valid  <= 1'b0;
         rk_round  <= 4'd0;
         round_key <= '0;
         done      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  key_q     <= key_in;
                  round_key <= key_in;
                  rk_round  <= 4'd0;
                  rk_valid  <= 1'b1;
                  rcnt_q    <= 4'd1;
                  rcon_q    <= 8'h01;
                  busy      <= 1'b1;
                  state_q   <= SUB;
               end else begin
                  rk_valid  <= 1'b0;
               end
            end
            SUB: begin
               rk_valid <= 1'b0;
               state_q  <= MIX;
            end
            MIX: begin
               key_q     <= key_d;
               round_key <= key_d;
               rk_valid  <= 1'b1;
               rk_round  <= rcnt_q;
               rcon_q    <= rcon_d;
               if (rcnt_q == 4'd10) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  rcnt_q  <= rcnt_q + 4'd1;
                  state_q <= SUB;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_expand.sv
// Scoreboard bench for key_expand: a FIPS-197 style reference expansion
// feeds an expectation queue; a negedge monitor checks every rk_valid pulse.
`timescale 1ns/1ps

module tb_key_expand;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [127:0] key_in = '0;
   logic         busy;
   logic         rk_valid;
   logic [3:0]   rk_round;
   logic [127:0] round_key;
   logic         done;

   key_expand dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .key_in    (key_in),
      .busy      (busy),
      .rk_valid  (rk_valid),
      .rk_round  (rk_round),
      .round_key (round_key),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] key;
      int           rnd;
      int           cyc;
      logic         last;
   } exp_t;

   exp_t         sb_q[$];
   int           cyc = 0;
   int           n_checks = 0;
   int           n_fail = 0;
   int           busy_from = 0;
   int           busy_to = -1;
   logic [7:0]   sbox_tab [256];
   logic [127:0] model_rk [11];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // S-box table via generator-3 log walk plus affine transform
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ ((q << 1) | (q >> 7)) ^ ((q << 2) | (q >> 6))
               ^ ((q << 3) | (q >> 5)) ^ ((q << 4) | (q >> 4)) ^ 8'h63;
         sbox_tab[p] = x;
      end while (p != 8'h01);
      sbox_tab[0] = 8'h63;
   endtask

   // Textbook word-array expansion w[0..43]
   task automatic model_expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rcon_tab [10];
      rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
                   sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
            tmp = tmp ^ {rcon_tab[i/4 - 1], 24'h000000};
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drive start at the current negedge and queue the 11 expected pulses
   task automatic issue(input logic [127:0] key, output int k);
      exp_t e;
      k = cyc;
      model_expand(key);
      for (int r = 0; r < 11; r++) begin
         e.key  = model_rk[r];
         e.rnd  = r;
         e.cyc  = k + 2*r + 1;
         e.last = (r == 10);
         sb_q.push_back(e);
      end
      busy_from = k + 1;
      busy_to   = k + 20;
      start     = 1'b1;
      key_in    = key;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor: busy window every cycle, scoreboard pop on each rk_valid
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         chk("busy", {127'b0, busy}, {127'b0, (cyc >= busy_from) && (cyc <= busy_to)});
         if (rk_valid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_rk_valid", {127'b0, rk_valid}, 128'd0);
            end else begin
               e = sb_q.pop_front();
               $display("rk cycle=%0d round=%0d key=%h done=%0b", cyc, rk_round, round_key, done);
               chk("round_key", round_key, e.key);
               chk("rk_round", {124'b0, rk_round}, e.rnd[127:0]);
               chk("done", {127'b0, done}, {127'b0, e.last});
               chk("pulse_cycle", cyc[127:0], e.cyc[127:0]);
            end
         end else begin
            chk("done_without_valid", {127'b0, done}, 128'd0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k, k2;
      build_sbox();

      // Reset state
      #1;
      chk("rst_round_key", round_key, 128'd0);
      chk("rst_rk_round", {124'b0, rk_round}, 128'd0);
      chk("rst_rk_valid", {127'b0, rk_valid}, 128'd0);
      chk("rst_done", {127'b0, done}, 128'd0);
      chk("rst_busy", {127'b0, busy}, 128'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // FIPS-197 key, then hold idle
      issue(128'h2b7e151628aed2a6abf7158809cf4f3c, k);
      @(negedge clk); start = 1'b0;
      wait_until(k + 22);
      chk("fips_hold_key", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("fips_hold_round", {124'b0, rk_round}, 128'd10);
      repeat (10) @(negedge clk);
      chk("fips_hold_key_late", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("idle_rk_valid", {127'b0, rk_valid}, 128'd0);

      // All-zero key
      issue(128'd0, k);
      @(negedge clk); start = 1'b0;
      wait_until(k + 22);
      chk("zero_round10", round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      // start held with changing key_in while busy
      issue(rand128(), k);
      @(negedge clk);
      while (cyc < k + 21) begin
         start  = 1'b1;
         key_in = rand128();
         @(negedge clk);
      end
      start = 1'b0;
      wait_until(k + 24);

      // Reset in cycle 8 of an expansion
      issue(rand128(), k);
      @(negedge clk); start = 1'b0;
      wait_until(k + 8);
      #2;
      rst = 1'b1;
      busy_to = -1;
      sb_q.delete();
      #1;
      chk("mid_rst_round_key", round_key, 128'd0);
      chk("mid_rst_rk_round", {124'b0, rk_round}, 128'd0);
      chk("mid_rst_rk_valid", {127'b0, rk_valid}, 128'd0);
      chk("mid_rst_done", {127'b0, done}, 128'd0);
      chk("mid_rst_busy", {127'b0, busy}, 128'd0);
      @(negedge clk); rst = 1'b0;
      repeat (8) @(negedge clk);
      issue(128'h2b7e151628aed2a6abf7158809cf4f3c, k);
      @(negedge clk); start = 1'b0;
      wait_until(k + 22);

      // Back-to-back: second start in the done cycle
      issue(rand128(), k);
      @(negedge clk); start = 1'b0;
      wait_until(k + 21);
      issue(rand128(), k2);
      @(negedge clk); start = 1'b0;
      wait_until(k2 + 22);

      // A few random keys with random idle gaps
      for (int n = 0; n < 4; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         issue(rand128(), k);
         @(negedge clk); start = 1'b0;
         wait_until(k + 22);
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
